tx_ctrl_seq: RTL and testbench

TX_CTRL_SEQ -- requirements
Module: tx_ctrl_seq

---
 rtl/tx_ctrl_seq.sv | 149 ++++++++++++++
 tb/tb_tx_ctrl_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ctrl_seq.sv
// Serialises register-file bytes and multi-byte ALU results onto a UART with a
// one-entry pending slot; excess requests are dropped and counted.
module tx_ctrl_seq #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int MSB_FIRST     = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Rd_D_Vld,
  input  logic [DATA_WIDTH-1:0]    Rd_Data,
  input  logic                     ALU_OUT_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     TX_Busy,
  output logic [DATA_WIDTH-1:0]    TX_Data,
  output logic                     TX_Valid,
  output logic                     Ctrl_Busy,
  output logic                     Overrun,
  output logic [7:0]               Drop_Cnt
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ALU_OUT_WIDTH;
  localparam int NB = AW / DW;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] frm_buf;
  logic [CW-1:0] frm_rem;
  logic          pend_vld, pend_alu;
  logic [AW-1:0] pend_dat;

  logic          start_pend, start_rd, start_alu, ld, advance;
  logic [AW-1:0] ld_word, next_buf;
  logic [CW-1:0] ld_cnt;
  logic          rd_left, alu_left, slot_free, slot_wr, slot_wr_alu;
  logic [AW-1:0] slot_wr_dat;
  logic [1:0]    n_drop;
  logic [8:0]    drop_sum;

  // Frame buffer always shifts right, so MSB-first frames are byte-reversed on load.
  function automatic logic [AW-1:0] order_bytes(input logic [AW-1:0] w);
    logic [AW-1:0] r;
    r = w;
    if (MSB_FIRST != 0)
      for (int k = 0; k < NB; k++) r[k*DW +: DW] = w[(NB-1-k)*DW +: DW];
    return r;
  endfunction

  always_comb begin
    state_nxt  = state;
    start_pend = 1'b0;
    start_rd   = 1'b0;
    start_alu  = 1'b0;
    advance    = 1'b0;
    ld_word    = '0;
    ld_cnt     = '0;
    case (state)
      IDLE: begin
        if (!TX_Busy) begin
          if (pend_vld) begin
            start_pend = 1'b1;
            ld_word    = pend_alu ? order_bytes(pend_dat) : pend_dat;
            ld_cnt     = pend_alu ? CW'(NB) : CW'(1);
            state_nxt  = PRESENT;
          end else if (Rd_D_Vld) begin
            start_rd  = 1'b1;
            ld_word   = AW'(Rd_Data);
            ld_cnt    = CW'(1);
            state_nxt = PRESENT;
          end else if (ALU_OUT_Valid) begin
            start_alu = 1'b1;
            ld_word   = order_bytes(ALU_OUT);
            ld_cnt    = CW'(NB);
            state_nxt = PRESENT;
          end
        end
      end
      PRESENT: if (TX_Busy) state_nxt = HOLD;
      HOLD: begin
        if (!TX_Busy) begin
          if (frm_rem > CW'(1)) begin
            advance   = 1'b1;
            state_nxt = PRESENT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A slot being drained this cycle may be refilled in the same cycle.
    ld          = start_pend | start_rd | start_alu;
    next_buf    = frm_buf >> DW;
    rd_left     = Rd_D_Vld && !start_rd;
    alu_left    = ALU_OUT_Valid && !start_alu;
    slot_free   = !pend_vld || start_pend;
    slot_wr     = slot_free && (rd_left || alu_left);
    slot_wr_alu = !rd_left;
    slot_wr_dat = rd_left ? AW'(Rd_Data) : ALU_OUT;
    n_drop      = {1'b0, rd_left} + {1'b0, alu_left} - {1'b0, slot_wr};
    drop_sum    = {1'b0, Drop_Cnt} + {7'b0, n_drop};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      frm_buf  <= '0;
      frm_rem  <= '0;
      pend_vld <= 1'b0;
      pend_alu <= 1'b0;
      pend_dat <= '0;
      TX_Data  <= '0;
      TX_Valid <= 1'b0;
      Overrun  <= 1'b0;
      Drop_Cnt <= '0;
    end else begin
      state    <= state_nxt;
      Overrun  <= (n_drop != 2'd0);
      Drop_Cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (ld) begin
        frm_buf  <= ld_word;
        frm_rem  <= ld_cnt;
        TX_Data  <= ld_word[DW-1:0];
        TX_Valid <= 1'b1;
      end else if (advance) begin
        frm_buf  <= next_buf;
        frm_rem  <= frm_rem - CW'(1);
        TX_Data  <= next_buf[DW-1:0];
        TX_Valid <= 1'b1;
      end else if (state == PRESENT && TX_Busy) begin
        TX_Valid <= 1'b0;
      end
      if (slot_wr) begin
        pend_vld <= 1'b1;
        pend_alu <= slot_wr_alu;
        pend_dat <= slot_wr_dat;
      end else if (start_pend) begin
        pend_vld <= 1'b0;
      end
    end
  end

  assign Ctrl_Busy = (state != IDLE) || pend_vld;

endmodule

// File: tb/tb_tx_ctrl_seq.sv
// Scoreboard bench: two UART models consume bytes from an LSB-first 16-bit
// instance and an MSB-first 32-bit instance.
module tb_tx_ctrl_seq;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        rd_vld_a = 1'b0, alu_vld_a = 1'b0, uart_busy_a = 1'b0, hold_busy = 1'b0;
  logic [7:0]  rd_dat_a = '0;
  logic [15:0] alu_a = '0;
  logic        tx_busy_a;
  logic [7:0]  tx_dat_a, drop_a;
  logic        tx_vld_a, cbusy_a, ovr_a;

  logic        rd_vld_b = 1'b0, alu_vld_b = 1'b0, uart_busy_b = 1'b0;
  logic [7:0]  rd_dat_b = '0;
  logic [31:0] alu_b = '0;
  logic [7:0]  tx_dat_b, drop_b;
  logic        tx_vld_b, cbusy_b, ovr_b;

  assign tx_busy_a = uart_busy_a | hold_busy;

  tx_ctrl_seq dut_a (
    .CLK(CLK), .RST(RST), .Rd_D_Vld(rd_vld_a), .Rd_Data(rd_dat_a),
    .ALU_OUT_Valid(alu_vld_a), .ALU_OUT(alu_a), .TX_Busy(tx_busy_a),
    .TX_Data(tx_dat_a), .TX_Valid(tx_vld_a), .Ctrl_Busy(cbusy_a),
    .Overrun(ovr_a), .Drop_Cnt(drop_a)
  );

  tx_ctrl_seq #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(32), .MSB_FIRST(1)) dut_b (
    .CLK(CLK), .RST(RST), .Rd_D_Vld(rd_vld_b), .Rd_Data(rd_dat_b),
    .ALU_OUT_Valid(alu_vld_b), .ALU_OUT(alu_b), .TX_Busy(uart_busy_b),
    .TX_Data(tx_dat_b), .TX_Valid(tx_vld_b), .Ctrl_Busy(cbusy_b),
    .Overrun(ovr_b), .Drop_Cnt(drop_b)
  );

  int n_chk = 0, n_fail = 0;
  int bytes_a = 0, bytes_b = 0, ovr_cnt_a = 0;
  int bc_a = 0, bc_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // UART models: accept a byte when idle, then stay busy for 10 cycles.
  always @(negedge CLK) begin
    if (ovr_a) ovr_cnt_a++;
    if (bc_a > 0) begin
      bc_a--;
      if (bc_a == 0) uart_busy_a = 1'b0;
    end else if (tx_vld_a && !tx_busy_a) begin
      check("a_byte_expected", 32'(q_a.size() != 0), 1);
      if (q_a.size() != 0) check("a_byte", 32'(tx_dat_a), 32'(q_a.pop_front()));
      bytes_a++;
      uart_busy_a = 1'b1;
      bc_a = 10;
    end
  end

  always @(negedge CLK) begin
    if (bc_b > 0) begin
      bc_b--;
      if (bc_b == 0) uart_busy_b = 1'b0;
    end else if (tx_vld_b && !uart_busy_b) begin
      check("b_byte_expected", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) check("b_byte", 32'(tx_dat_b), 32'(q_b.pop_front()));
      bytes_b++;
      uart_busy_b = 1'b1;
      bc_b = 10;
    end
  end

  task automatic pulse_rd(input logic [7:0] d);
    rd_dat_a = d; rd_vld_a = 1'b1;
    @(posedge CLK); #1;
    rd_vld_a = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] d);
    alu_a = d; alu_vld_a = 1'b1;
    @(posedge CLK); #1;
    alu_vld_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int k = 0;
    while (k < 600 && (cbusy_a || tx_busy_a || q_a.size() != 0)) begin
      @(posedge CLK); #1; k++;
    end
    check({tag, "_idle_in_time"}, 32'(k < 600), 1);
  endtask

  task automatic wait_idle_b(input string tag);
    int k = 0;
    while (k < 600 && (cbusy_b || uart_busy_b || q_b.size() != 0)) begin
      @(posedge CLK); #1; k++;
    end
    check({tag, "_idle_in_time"}, 32'(k < 600), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, b0, k, seen;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_tx_valid", 32'(tx_vld_a), 0);
    check("rst_tx_data", 32'(tx_dat_a), 0);
    check("rst_ctrl_busy", 32'(cbusy_a), 0);
    check("rst_overrun", 32'(ovr_a), 0);
    check("rst_drop_cnt", 32'(drop_a), 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Single register-file byte, one-cycle latency
    q_a.push_back(8'hA5);
    pulse_rd(8'hA5);
    check("rd_lat_valid", 32'(tx_vld_a), 1);
    check("rd_lat_data", 32'(tx_dat_a), 32'h A5);
    wait_idle_a("rd");
    check("rd_byte_count", 32'(bytes_a), 1);

    // ALU result LSB first; input changes after capture must not leak
    q_a.push_back(8'h34); q_a.push_back(8'h12);
    pulse_alu(16'h1234);
    alu_a = 16'hFFFF;
    wait_idle_a("alu");
    check("alu_byte_count", 32'(bytes_a), 3);

    // 32-bit MSB-first instance
    q_b.push_back(8'hDE); q_b.push_back(8'hAD); q_b.push_back(8'hBE); q_b.push_back(8'hEF);
    alu_b = 32'hDEADBEEF; alu_vld_b = 1'b1;
    @(posedge CLK); #1;
    alu_vld_b = 1'b0;
    alu_b = 32'hFFFFFFFF;
    wait_idle_b("msb");
    check("msb_byte_count", 32'(bytes_b), 4);

    // Simultaneous requests: register byte first, ALU parked in the slot
    ovr0 = ovr_cnt_a;
    q_a.push_back(8'h11); q_a.push_back(8'hAA); q_a.push_back(8'hBB);
    rd_dat_a = 8'h11; alu_a = 16'hBBAA; rd_vld_a = 1'b1; alu_vld_a = 1'b1;
    @(posedge CLK); #1;
    rd_vld_a = 1'b0; alu_vld_a = 1'b0;
    wait_idle_a("both");
    check("both_no_overrun", 32'(ovr_cnt_a - ovr0), 0);
    check("both_drop_cnt", 32'(drop_a), 0);
    check("both_byte_count", 32'(bytes_a), 6);

    // Frame in flight, slot filled, third request dropped
    q_a.push_back(8'h66); q_a.push_back(8'h55); q_a.push_back(8'h77);
    pulse_alu(16'h5566);
    pulse_rd(8'h77);
    pulse_rd(8'h88);
    check("drop_overrun_pulse", 32'(ovr_a), 1);
    check("drop_cnt_one", 32'(drop_a), 1);
    @(posedge CLK); #1;
    check("drop_overrun_clears", 32'(ovr_a), 0);
    wait_idle_a("drop");

    // UART held busy: request parks in the slot, then 300 more are dropped
    hold_busy = 1'b1;
    @(posedge CLK); #1;
    q_a.push_back(8'h99);
    pulse_rd(8'h99);
    check("held_no_start", 32'(tx_vld_a), 0);
    check("held_slot_busy", 32'(cbusy_a), 1);
    rd_dat_a = 8'h42; rd_vld_a = 1'b1;
    repeat (300) @(posedge CLK);
    #1;
    rd_vld_a = 1'b0;
    check("drop_cnt_saturated", 32'(drop_a), 32'hFF);
    check("held_still_idle", 32'(tx_vld_a), 0);
    hold_busy = 1'b0;
    wait_idle_a("slot_drain");

    // Reset in HOLD between ALU bytes abandons the frame
    b0 = bytes_a;
    q_a.push_back(8'hFE);
    pulse_alu(16'hCAFE);
    k = 0;
    while (k < 50 && bytes_a == b0) begin
      @(posedge CLK); #1; k++;
    end
    check("mid_first_byte_in_time", 32'(k < 50), 1);
    repeat (3) @(posedge CLK);
    #1;
    check("mid_in_hold", 32'(cbusy_a && !tx_vld_a), 1);
    RST = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_vld_a), 0);
    check("mid_rst_tx_data", 32'(tx_dat_a), 0);
    check("mid_rst_ctrl_busy", 32'(cbusy_a), 0);
    check("mid_rst_drop_cnt", 32'(drop_a), 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (tx_vld_a) seen = 1;
    end
    check("post_rst_no_tx", 32'(seen), 0);

    check("q_a_drained", 32'(q_a.size()), 0);
    check("q_b_drained", 32'(q_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
